// File: rtl/prog_loader.sv
// prog_loader: streams host words into IROM from address 0, pads the rest with NOP_WORD, then releases halt.
module prog_loader #(
  parameter type i_t = logic [31:0],
  parameter type pc_t = logic [3:0],
  parameter int DEPTH = 16,
  parameter i_t NOP_WORD = '0
) (
  input logic CLK,
  input logic nRST,
  input logic start,
  input i_t ld_data,
  input logic ld_valid,
  input logic ld_last,
  output logic ld_ready,
  output logic busy,
  output logic done,
  output logic err,
  output i_t idata,
  output pc_t iaddr,
  output logic iwen,
  output logic halt
);
  typedef enum logic [2:0] {IDLE, LOAD, PAD, RUN, ERROR} state_t;
  localparam pc_t LAST = pc_t'(DEPTH - 1);
  state_t state, nxt;
  pc_t wa;
  logic go, acc, wr, at_end, fin, fin_q;
  always_comb begin
    go = start && (state == IDLE || state == RUN || state == ERROR);
    acc = ld_valid && ld_ready && state == LOAD;
    at_end = wa == LAST;
    wr = acc || state == PAD;
    nxt = go ? LOAD
        : acc ? (ld_last ? (at_end ? RUN : PAD) : (at_end ? ERROR : LOAD))
        : (state == PAD && at_end) ? RUN : state;
    fin = (state == LOAD || state == PAD) && nxt == RUN;
  end
  // done and halt release trail the final write by one cycle, hence fin_q
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      wa <= '0;
      iwen <= 1'b0;
      iaddr <= '0;
      idata <= '0;
      ld_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      halt <= 1'b1;
      fin_q <= 1'b0;
    end else begin
      state <= nxt;
      wa <= go ? '0 : (wr && !at_end) ? wa + pc_t'(1) : wa;
      iwen <= wr;
      iaddr <= wr ? wa : iaddr;
      idata <= wr ? (acc ? ld_data : NOP_WORD) : idata;
      ld_ready <= nxt == LOAD;
      busy <= nxt == LOAD || nxt == PAD;
      fin_q <= fin;
      done <= fin_q && !go;
      halt <= go || (halt && !fin_q);
      err <= !go && (err || (acc && !ld_last && at_end));
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed vectors against a write-schedule model of the loader.
module tb_prog_loader;
  localparam int DEPTH = 16;
  typedef logic [31:0] i_t;
  typedef logic [3:0] pc_t;
  localparam i_t NOP = 32'h0000_0013;
  logic CLK = 0, nRST = 0, start = 0, ld_valid = 0, ld_last = 0;
  i_t ld_data = '0;
  logic ld_ready, busy, done, err, iwen, halt;
  i_t idata;
  pc_t iaddr;
  int vectors = 0, miscompares = 0, cyc = 0, t0 = 0, done_cyc = -1;
  bit done_seen = 0, armed = 0;
  int wr_cyc[DEPTH];

  prog_loader #(.i_t(i_t), .pc_t(pc_t), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .ld_data(ld_data), .ld_valid(ld_valid),
    .ld_last(ld_last), .ld_ready(ld_ready), .busy(busy), .done(done), .err(err),
    .idata(idata), .iaddr(iaddr), .iwen(iwen), .halt(halt));

  always #5 CLK = ~CLK;

  // model: a queue of writes still owed to the IROM, one drained per cycle; a marker ends a good load
  typedef struct { bit marker; int addr; i_t data; } wr_t;
  wr_t pend[$];
  wr_t f;
  bit m_loading = 0, m_halt = 1, m_err = 0, m_done = 0, m_we = 0, m_acc, m_ovf;
  int m_n = 0, m_addr = 0;
  i_t m_data = '0;

  initial forever begin
    @(posedge CLK);
    cyc++;
    if (!nRST) begin
      pend.delete();
      m_loading = 0; m_n = 0; m_halt = 1; m_err = 0; m_done = 0; m_we = 0; armed = 1;
    end else begin
      m_acc = m_loading && ld_valid;
      m_ovf = 0;
      if (m_acc) begin
        pend.push_back('{marker: 1'b0, addr: m_n, data: ld_data});
        if (ld_last) begin
          for (int a = m_n + 1; a < DEPTH; a++) pend.push_back('{marker: 1'b0, addr: a, data: NOP});
          pend.push_back('{marker: 1'b1, addr: 0, data: NOP});
          m_loading = 0;
        end else if (m_n == DEPTH - 1) begin
          m_loading = 0;
          m_ovf = 1;
        end
        m_n++;
      end else if (start && !m_loading && pend.size() <= 1) begin
        pend.delete();
        m_loading = 1; m_n = 0; m_halt = 1; m_err = 0;
      end
      m_we = 0;
      m_done = 0;
      if (pend.size() > 0) begin
        f = pend.pop_front();
        if (f.marker) begin
          m_done = 1;
          m_halt = 0;
        end else begin
          m_we = 1;
          m_addr = f.addr;
          m_data = f.data;
        end
      end
      if (m_ovf) m_err = 1;
    end
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(negedge CLK);
    if (armed) begin
      chk("iwen", iwen, m_we);
      chk("ld_ready", ld_ready, m_loading);
      chk("busy", busy, m_loading || pend.size() > 1);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("halt", halt, m_halt);
      if (m_we) begin
        chk("iaddr", iaddr, m_addr);
        chk("idata", idata, m_data);
      end
      if (done) begin done_seen = 1; done_cyc = cyc; end
      if (iwen) wr_cyc[iaddr] = cyc;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_track();
    for (int i = 0; i < DEPTH; i++) wr_cyc[i] = -1;
    done_seen = 0;
    done_cyc = -1;
  endtask

  task automatic pulse_start();
    t0 = cyc;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic send(input i_t d, input bit last);
    bit r;
    ld_data = d;
    ld_valid = 1;
    ld_last = last;
    for (int i = 0; i < 20; i++) begin
      r = ld_ready;
      tick();
      if (r) return;
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic idle_host();
    ld_valid = 0;
    ld_last = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      if (done_seen) return;
      tick();
    end
    chk("done_timeout", 0, 1);
  endtask

  initial begin
    clear_track();
    tick(); tick();
    chk("rst_halt", halt, 1);
    chk("rst_iwen", iwen, 0);
    chk("rst_iaddr", iaddr, 0);
    chk("rst_idata", idata, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    start = 1;
    tick();
    chk("start_in_reset", ld_ready, 0);
    start = 0;
    nRST = 1;
    repeat (3) tick();
    chk("idle_halt", halt, 1);

    clear_track();
    pulse_start();
    send(32'h11, 0); send(32'h22, 0); send(32'h33, 1);
    idle_host();
    wait_done();
    chk("short_first_wr", wr_cyc[0] - t0, 2);
    chk("short_last_word", wr_cyc[2] - t0, 4);
    chk("short_nop3", wr_cyc[3] - t0, 5);
    chk("short_nop15", wr_cyc[15] - t0, 17);
    chk("short_done", done_cyc - t0, 18);
    tick();
    chk("short_run_halt", halt, 0);

    clear_track();
    pulse_start();
    chk("reload_halt", halt, 1);
    for (int i = 0; i < DEPTH; i++) send(32'hA000 + i, i == DEPTH - 1);
    idle_host();
    wait_done();
    chk("full_restart0", wr_cyc[0] - t0, 2);
    chk("full_done_after15", done_cyc - wr_cyc[15], 1);
    chk("full_done", done_cyc - t0, 18);

    clear_track();
    pulse_start();
    for (int i = 0; i < DEPTH; i++) send(32'hB000 + i, 0);
    idle_host();
    repeat (3) tick();
    chk("ovf_wr15", wr_cyc[15] - t0, 17);
    chk("ovf_err", err, 1);
    chk("ovf_halt", halt, 1);
    chk("ovf_ready", ld_ready, 0);
    chk("ovf_no_done", done_seen, 0);

    clear_track();
    pulse_start();
    chk("restart_clears_err", err, 0);
    send(32'hC0, 0); send(32'hC1, 0);
    idle_host();
    repeat (3) begin
      tick();
      chk("stall_ready", ld_ready, 1);
    end
    send(32'hC2, 0); send(32'hC3, 1);
    idle_host();
    wait_done();
    chk("stall_gap", wr_cyc[2] - wr_cyc[1], 4);

    clear_track();
    pulse_start();
    send(32'hD0, 0); send(32'hD1, 0);
    idle_host();
    nRST = 0;
    tick();
    chk("midrst_iwen", iwen, 0);
    chk("midrst_halt", halt, 1);
    chk("midrst_ready", ld_ready, 0);
    nRST = 1;
    repeat (10) tick();
    chk("midrst_halt_held", halt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
